// File: rtl/video_stream_source.sv
// Pixel stream producer: scans x/y into the video chain under a credit limit and
// re-times the chain output through a small FIFO to a valid/ready sink.
// Optional build macro: VIDEO_STREAM_SOURCE_TEST_PATTERN_EN (adds tp_en colour bars).
module video_stream_source #(
   parameter int HMAX       = 640,
   parameter int VMAX       = 480,
   parameter int CD         = 12,
   parameter int LAT        = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          sync_clr,
`ifdef VIDEO_STREAM_SOURCE_TEST_PATTERN_EN
   input  logic          tp_en,
`endif
   output logic          inc,
   output logic [10:0]   x,
   output logic [10:0]   y,
   output logic          frame_start,
   output logic          frame_end,
   input  logic [CD-1:0] pipe_rgb,
   output logic [CD:0]   so_data,
   output logic          so_valid,
   input  logic          so_ready,
   output logic          ovf_err
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int FW = CD / 3;

   logic [10:0]   x_q, x_d, y_q, y_d;
   logic [LAT:1]  vld_pipe_q, vld_pipe_d, sof_pipe_q, sof_pipe_d;
   logic [CW-1:0] infl_cnt_q, infl_cnt_d, fifo_cnt_q, fifo_cnt_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic          ovf_q, ovf_d;
   logic [CD:0]   mem_q [FIFO_DEPTH];
   logic [CW:0]   credit_used;
   logic          retire, pop, full, push_ok, wr_en;
   logic [CD-1:0] cap_rgb;

`ifdef VIDEO_STREAM_SOURCE_TEST_PATTERN_EN
   logic [LAT:1]  tp_pipe_q, tp_pipe_d;
   logic [CD-1:0] bar_pipe_q [1:LAT];
   logic [CD-1:0] bar_pipe_d [1:LAT];
   logic [CD-1:0] bar_val;

   always_comb begin
      bar_val = {{FW{x_q[8]}}, {FW{x_q[7]}}, {FW{x_q[6]}}};
      tp_pipe_d = tp_pipe_q;
      bar_pipe_d = bar_pipe_q;
      tp_pipe_d[1] = inc && tp_en;
      bar_pipe_d[1] = bar_val;
      for (int k = 2; k <= LAT; k++) begin
         tp_pipe_d[k] = tp_pipe_q[k-1];
         bar_pipe_d[k] = bar_pipe_q[k-1];
      end
      if (sync_clr) tp_pipe_d = '0;
      cap_rgb = tp_pipe_q[LAT] ? bar_pipe_q[LAT] : pipe_rgb;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) tp_pipe_q <= '0;
      else          tp_pipe_q <= tp_pipe_d;
      bar_pipe_q <= bar_pipe_d;
   end
`else
   assign cap_rgb = pipe_rgb;
`endif

   assign x        = x_q;
   assign y        = y_q;
   assign so_valid = (fifo_cnt_q != '0);
   assign so_data  = mem_q[rd_ptr_q];
   assign ovf_err  = ovf_q;

   always_comb begin
      // Credit counts every beat already issued but not yet popped.
      credit_used = {1'b0, fifo_cnt_q} + {1'b0, infl_cnt_q};
      inc         = !sync_clr && (credit_used < (CW+1)'(FIFO_DEPTH));
      frame_start = inc && (x_q == '0) && (y_q == '0);
      frame_end   = inc && (x_q == 11'(HMAX-1)) && (y_q == 11'(VMAX-1));
      retire      = vld_pipe_q[LAT];
      pop         = so_valid && so_ready;
      full        = (fifo_cnt_q == CW'(FIFO_DEPTH));
      push_ok     = retire && (!full || pop);
      wr_en       = push_ok && !sync_clr;

      x_d = x_q;
      y_d = y_q;
      if (inc) begin
         if (x_q == 11'(HMAX-1)) begin
            x_d = '0;
            y_d = (y_q == 11'(VMAX-1)) ? '0 : y_q + 11'd1;
         end else begin
            x_d = x_q + 11'd1;
         end
      end

      vld_pipe_d    = vld_pipe_q;
      sof_pipe_d    = sof_pipe_q;
      vld_pipe_d[1] = inc;
      sof_pipe_d[1] = frame_start;
      for (int k = 2; k <= LAT; k++) begin
         vld_pipe_d[k] = vld_pipe_q[k-1];
         sof_pipe_d[k] = sof_pipe_q[k-1];
      end

      infl_cnt_d = infl_cnt_q;
      if (inc && !retire)      infl_cnt_d = infl_cnt_q + CW'(1);
      else if (!inc && retire) infl_cnt_d = infl_cnt_q - CW'(1);

      fifo_cnt_d = fifo_cnt_q + CW'(push_ok) - CW'(pop);
      wr_ptr_d   = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      ovf_d      = ovf_q | (retire && !push_ok);

      if (sync_clr) begin
         x_d        = '0;
         y_d        = '0;
         vld_pipe_d = '0;
         sof_pipe_d = '0;
         infl_cnt_d = '0;
         fifo_cnt_d = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         x_q        <= '0;
         y_q        <= '0;
         vld_pipe_q <= '0;
         sof_pipe_q <= '0;
         infl_cnt_q <= '0;
         fifo_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ovf_q      <= 1'b0;
      end else begin
         x_q        <= x_d;
         y_q        <= y_d;
         vld_pipe_q <= vld_pipe_d;
         sof_pipe_q <= sof_pipe_d;
         infl_cnt_q <= infl_cnt_d;
         fifo_cnt_q <= fifo_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ovf_q      <= ovf_d;
      end
   end

   // Storage needs no reset: so_data is only meaningful while so_valid is high.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= {cap_rgb, sof_pipe_q[LAT]};
   end
endmodule

// File: tb/tb_video_stream_source.sv
// Scoreboard bench for video_stream_source on a reduced 12x5 raster so full
// frames fit in a short run; the chain is modelled as an LAT-cycle echo.
module tb_video_stream_source;
   localparam int HMAX = 12;
   localparam int VMAX = 5;
   localparam int CD   = 12;
   localparam int LAT  = 2;
   localparam int FD   = 4;
   localparam int NPIX = HMAX * VMAX;

   logic          clk, reset_n, sync_clr, so_ready;
   logic          inc, frame_start, frame_end, so_valid, ovf_err;
   logic [10:0]   x, y;
   logic [CD-1:0] pipe_rgb;
   logic [CD:0]   so_data;
`ifdef VIDEO_STREAM_SOURCE_TEST_PATTERN_EN
   logic          tp_en;
`endif

   video_stream_source #(.HMAX(HMAX), .VMAX(VMAX), .CD(CD), .LAT(LAT), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .reset_n(reset_n), .sync_clr(sync_clr),
`ifdef VIDEO_STREAM_SOURCE_TEST_PATTERN_EN
      .tp_en(tp_en),
`endif
      .inc(inc), .x(x), .y(y), .frame_start(frame_start), .frame_end(frame_end),
      .pipe_rgb(pipe_rgb), .so_data(so_data), .so_valid(so_valid), .so_ready(so_ready),
      .ovf_err(ovf_err));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nvec, nerr, cyc, n_inc, n_pop, n_start, first_inc, first_vld;
   logic [CD:0]   sbq[$];
   logic [CD-1:0] hist [0:LAT];
   logic [10:0]   ex, ey;
   logic          s_inc, s_fs, s_fe;
   logic [10:0]   s_x, s_y;

   // One clock: sample at negedge, score issues and pops, update the chain echo,
   // then return just after the next posedge where inputs may be changed.
   task automatic cycle();
      logic [CD:0] exp_b;
      logic        e_fs, e_fe;
      @(negedge clk);
      cyc++;
      s_inc = inc; s_x = x; s_y = y; s_fs = frame_start; s_fe = frame_end;
      if (!reset_n || sync_clr) begin
         sbq.delete();
         ex = '0;
         ey = '0;
      end else begin
         if (inc === 1'b1) begin
            e_fs = (ex == 0) && (ey == 0);
            e_fe = (ex == 11'(HMAX-1)) && (ey == 11'(VMAX-1));
            nvec++;
            if (x !== ex || y !== ey || frame_start !== e_fs || frame_end !== e_fe) begin
               nerr++;
               $display("FAIL scan: got x=%0d y=%0d fs=%b fe=%b, expected x=%0d y=%0d fs=%b fe=%b",
                        x, y, frame_start, frame_end, ex, ey, e_fs, e_fe);
            end
            sbq.push_back({ex[3:0], ey[3:0], 4'h5, e_fs});
            if (ex == 11'(HMAX-1)) begin
               ex = '0;
               ey = (ey == 11'(VMAX-1)) ? 11'd0 : ey + 11'd1;
            end else begin
               ex = ex + 11'd1;
            end
            n_inc++;
            if (first_inc < 0) first_inc = cyc;
         end
         if (so_valid === 1'b1 && first_vld < 0) first_vld = cyc;
         if (so_valid === 1'b1 && so_ready) begin
            nvec++;
            if (sbq.size() == 0) begin
               nerr++;
               $display("FAIL beat: got %h with no beat expected", so_data);
            end else begin
               exp_b = sbq.pop_front();
               if (so_data !== exp_b) begin
                  nerr++;
                  $display("FAIL beat: got %h, expected %h", so_data, exp_b);
               end
            end
            n_pop++;
            if (so_data[0] === 1'b1) n_start++;
         end
      end
      for (int k = LAT; k >= 1; k--) hist[k] = hist[k-1];
      hist[0] = {x[3:0], y[3:0], 4'h5};
      pipe_rgb = hist[LAT];
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      sync_clr = 1'b0;
      cycle();
      cycle();
      reset_n = 1'b1;
      first_inc = -1;
      first_vld = -1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      so_ready = 1'b0;
      cycle();
      cycle();
      nvec += 4;
      if (x !== 11'd0)    begin nerr++; $display("FAIL reset_x: got %0d, expected 0", x); end
      if (y !== 11'd0)    begin nerr++; $display("FAIL reset_y: got %0d, expected 0", y); end
      if (so_valid !== 0) begin nerr++; $display("FAIL reset_valid: got %b, expected 0", so_valid); end
      if (ovf_err !== 0)  begin nerr++; $display("FAIL reset_ovf: got %b, expected 0", ovf_err); end
      reset_n = 1'b1;
   endtask

   task automatic test_stream();
      int p0, s0, g;
      so_ready = 1'b1;
      do_reset();
      p0 = n_pop; s0 = n_start; g = 0;
      while (n_pop - p0 < NPIX && g < 1000) begin cycle(); g++; end
      nvec += 4;
      if (n_pop - p0 != NPIX) begin nerr++; $display("FAIL stream_count: got %0d beats, expected %0d", n_pop - p0, NPIX); end
      if (n_start - s0 != 1) begin nerr++; $display("FAIL stream_starts: got %0d, expected 1", n_start - s0); end
      if (first_vld - first_inc != LAT + 1) begin
         nerr++; $display("FAIL stream_latency: got %0d, expected %0d", first_vld - first_inc, LAT + 1);
      end
      if (ovf_err !== 0) begin nerr++; $display("FAIL stream_ovf: got %b, expected 0", ovf_err); end
   endtask

   task automatic test_stall();
      int i0, p0, g;
      logic [CD:0] first_b;
      so_ready = 1'b0;
      do_reset();
      i0 = n_inc;
      for (int i = 0; i < 20; i++) cycle();
      first_b = {4'h0, 4'h0, 4'h5, 1'b1};
      nvec += 3;
      if (n_inc - i0 != FD) begin nerr++; $display("FAIL stall_issues: got %0d, expected %0d", n_inc - i0, FD); end
      if (so_valid !== 1'b1) begin nerr++; $display("FAIL stall_valid: got %b, expected 1", so_valid); end
      if (so_data !== first_b) begin nerr++; $display("FAIL stall_head: got %h, expected %h", so_data, first_b); end
      so_ready = 1'b1;
      p0 = n_pop; g = 0;
      while (n_pop - p0 < FD && g < 50) begin cycle(); g++; end
      nvec++;
      if (n_pop - p0 < FD) begin nerr++; $display("FAIL stall_release: got %0d beats, expected %0d", n_pop - p0, FD); end
   endtask

   task automatic test_random();
      int p0, s0, g;
      so_ready = 1'b0;
      do_reset();
      p0 = n_pop; s0 = n_start; g = 0;
      while (n_pop - p0 < 3 * NPIX && g < 4000) begin
         so_ready = ($urandom_range(0, 9) < 3);
         cycle();
         g++;
      end
      nvec += 3;
      if (n_pop - p0 != 3 * NPIX) begin nerr++; $display("FAIL random_count: got %0d, expected %0d", n_pop - p0, 3 * NPIX); end
      if (n_start - s0 != 3) begin nerr++; $display("FAIL random_starts: got %0d, expected 3", n_start - s0); end
      if (ovf_err !== 0) begin nerr++; $display("FAIL random_ovf: got %b, expected 0", ovf_err); end
   endtask

   task automatic test_wrap();
      int g, s0;
      so_ready = 1'b1;
      do_reset();
      g = 0;
      cycle();
      while (!(s_inc === 1'b1 && s_fe === 1'b1) && g < 500) begin cycle(); g++; end
      nvec += 2;
      if (s_fe !== 1'b1) begin nerr++; $display("FAIL wrap_end: got fe=%b, expected 1", s_fe); end
      if (s_x !== 11'(HMAX-1) || s_y !== 11'(VMAX-1)) begin
         nerr++; $display("FAIL wrap_end_xy: got %0d,%0d, expected %0d,%0d", s_x, s_y, HMAX-1, VMAX-1);
      end
      s0 = n_start; g = 0;
      cycle();
      while (s_inc !== 1'b1 && g < 50) begin cycle(); g++; end
      nvec++;
      if (s_x !== 11'd0 || s_y !== 11'd0 || s_fs !== 1'b1) begin
         nerr++; $display("FAIL wrap_next: got x=%0d y=%0d fs=%b, expected 0 0 1", s_x, s_y, s_fs);
      end
      for (int i = 0; i < 10; i++) cycle();
      nvec++;
      if (n_start - s0 != 1) begin nerr++; $display("FAIL wrap_start_beat: got %0d, expected 1", n_start - s0); end
   endtask

   task automatic test_sync_clr();
      int g, s0;
      so_ready = 1'b1;
      do_reset();
      g = 0;
      cycle();
      while (!(s_inc === 1'b1 && s_x == 11'd7 && s_y == 11'd2) && g < 300) begin cycle(); g++; end
      so_ready = 1'b0;
      for (int i = 0; i < 4; i++) cycle();
      nvec++;
      if (so_valid !== 1'b1) begin nerr++; $display("FAIL clr_pre_valid: got %b, expected 1", so_valid); end
      sync_clr = 1'b1;
      cycle();
      nvec += 3;
      if (s_inc !== 1'b0) begin nerr++; $display("FAIL clr_inc: got %b, expected 0", s_inc); end
      if (so_valid !== 1'b0) begin nerr++; $display("FAIL clr_valid: got %b, expected 0", so_valid); end
      if (x !== 11'd0 || y !== 11'd0) begin nerr++; $display("FAIL clr_xy: got %0d,%0d, expected 0,0", x, y); end
      sync_clr = 1'b0;
      s0 = n_start;
      cycle();
      nvec++;
      if (s_inc !== 1'b1 || s_x !== 11'd0 || s_y !== 11'd0 || s_fs !== 1'b1) begin
         nerr++; $display("FAIL clr_next: got inc=%b x=%0d y=%0d fs=%b, expected 1 0 0 1", s_inc, s_x, s_y, s_fs);
      end
      so_ready = 1'b1;
      for (int i = 0; i < 10; i++) cycle();
      nvec++;
      if (n_start - s0 != 1) begin nerr++; $display("FAIL clr_start_beat: got %0d, expected 1", n_start - s0); end
   endtask

   task automatic test_mid_reset();
      int p0, g;
      so_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 25; i++) cycle();
      reset_n = 1'b0;
      cycle();
      nvec += 3;
      if (x !== 11'd0 || y !== 11'd0) begin nerr++; $display("FAIL mid_reset_xy: got %0d,%0d, expected 0,0", x, y); end
      if (so_valid !== 1'b0) begin nerr++; $display("FAIL mid_reset_valid: got %b, expected 0", so_valid); end
      if (ovf_err !== 1'b0) begin nerr++; $display("FAIL mid_reset_ovf: got %b, expected 0", ovf_err); end
      reset_n = 1'b1;
      p0 = n_pop; g = 0;
      while (n_pop - p0 < 20 && g < 200) begin cycle(); g++; end
      nvec++;
      if (n_pop - p0 < 20) begin nerr++; $display("FAIL mid_reset_resume: got %0d beats, expected 20", n_pop - p0); end
   endtask

   initial begin
      nvec = 0; nerr = 0; cyc = 0; n_inc = 0; n_pop = 0; n_start = 0;
      first_inc = -1; first_vld = -1;
      ex = '0; ey = '0;
      reset_n = 1'b0; sync_clr = 1'b0; so_ready = 1'b0; pipe_rgb = '0;
      for (int k = 0; k <= LAT; k++) hist[k] = '0;
`ifdef VIDEO_STREAM_SOURCE_TEST_PATTERN_EN
      tp_en = 1'b0;
`endif
      test_reset();
      test_stream();
      test_stall();
      test_random();
      test_wrap();
      test_sync_clr();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
